// File: rtl/pipelined_write_rx_pkg.sv
// rtl/pipelined_write_rx_pkg.sv - shared types and constants for the pipelined write receiver
package pipelined_write_rx_pkg;

    localparam int MAX_WR_CYCLES       = 4;
    localparam int WR_WIDTH            = 8;
    localparam int WR_RX_PAYLOAD_WIDTH = MAX_WR_CYCLES * WR_WIDTH;
    localparam int WR_RX_ERR_E_WIDTH   = 3;
    localparam int TIMEOUT_CYCLES      = 16;

    typedef enum logic [2:0] {
        WRITE_TYPE_STD          = 3'd0,
        WRITE_TYPE_MULTI_WDONE  = 3'd1,
        WRITE_TYPE_SINGLE_WDONE = 3'd2
    } write_type_e;

    typedef enum logic [1:0] {
        CYC_IDLE  = 2'd0,
        CYC_VALID = 2'd1,
        CYC_DONE  = 2'd2
    } cycle_type_e;

    typedef enum logic [WR_RX_ERR_E_WIDTH-1:0] {
        WR_RX_ERR_NONE         = 3'd0,
        WR_RX_ERR_BAD_TYPE     = 3'd1,
        WR_RX_ERR_EARLY_DONE   = 3'd2,
        WR_RX_ERR_MISSING_DONE = 3'd3,
        WR_RX_ERR_OVERRUN      = 3'd4,
        WR_RX_ERR_TIMEOUT      = 3'd5
    } wr_rx_err_e;

    // Bus layout: cmd = {vld, write_type[2:0], num_cycles[1:0], rsvd[3:0]}
    typedef struct packed {
        logic       vld;
        logic [2:0] write_type;
        logic [1:0] num_cycles;
        logic [3:0] rsvd;
    } write_cmd_t;

    typedef struct packed {
        logic [1:0]          cycle_type;
        logic [WR_WIDTH-1:0] dat;
    } write_data_t;

    typedef enum logic {ST_IDLE, ST_DATA} rx_state_e;

endpackage

// File: rtl/pipelined_write_rx_obuf.sv
// rtl/pipelined_write_rx_obuf.sv - one-entry valid/ready output holding register with overrun detect
module pipelined_write_rx_obuf
    import pipelined_write_rx_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_push,
    input  logic [WR_RX_PAYLOAD_WIDTH-1:0] i_dat,
    input  logic [2:0]                     i_num,
    input  logic [2:0]                     i_type,
    input  logic                           i_rdy,
    output logic                           o_vld,
    output logic [WR_RX_PAYLOAD_WIDTH-1:0] o_dat,
    output logic [2:0]                     o_num,
    output logic [2:0]                     o_type,
    output logic                           o_overrun
);

    logic w_load;

    // A push may land in the same cycle the held entry drains.
    assign w_load    = i_push && (!o_vld || i_rdy);
    assign o_overrun = i_push && o_vld && !i_rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_vld  <= 1'b0;
            o_dat  <= '0;
            o_num  <= '0;
            o_type <= '0;
        end else if (w_load) begin
            o_vld  <= 1'b1;
            o_dat  <= i_dat;
            o_num  <= i_num;
            o_type <= i_type;
        end else if (o_vld && i_rdy) begin
            o_vld  <= 1'b0;
        end
    end

endmodule

// File: rtl/pipelined_write_rx.sv
// rtl/pipelined_write_rx.sv - pipelined write receiver; optional PIPELINED_WRITE_RX_TIMEOUT_EN bubble timeout
module pipelined_write_rx
    import pipelined_write_rx_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst,
    input  logic [9:0]                     wr_bus_i,
    output logic                           out_vld_o,
    input  logic                           out_rdy_i,
    output logic [WR_RX_PAYLOAD_WIDTH-1:0] out_dat_o,
    output logic [2:0]                     out_num_o,
    output logic [2:0]                     out_type_o,
    output logic                           wdone_o,
    output logic                           err_vld_o,
    output logic [WR_RX_ERR_E_WIDTH-1:0]   err_code_o
);

    localparam int CNT_W = $clog2(MAX_WR_CYCLES);

    rx_state_e                    r_state, w_state_nxt;
    logic [CNT_W-1:0]             r_cnt, r_last;
    logic [2:0]                   r_type;
    logic [WR_RX_PAYLOAD_WIDTH-1:0] r_asm, w_payload;
    write_cmd_t                   w_cmd;
    write_data_t                  w_dat;
    logic                         w_accept, w_store, w_complete, w_err, w_wdone, w_overrun;
    wr_rx_err_e                   w_err_code;
    logic                         w_unused_rsvd;

    assign w_cmd         = write_cmd_t'(wr_bus_i);
    assign w_dat         = write_data_t'(wr_bus_i);
    assign w_unused_rsvd = ^w_cmd.rsvd;
    assign w_payload     = r_asm | ({{(WR_RX_PAYLOAD_WIDTH-WR_WIDTH){1'b0}}, w_dat.dat} << {r_cnt, 3'b000});

`ifdef PIPELINED_WRITE_RX_TIMEOUT_EN
    localparam int BUB_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [BUB_W-1:0] r_bub;
    logic             w_bubble;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_store     = 1'b0;
        w_complete  = 1'b0;
        w_err       = 1'b0;
        w_err_code  = WR_RX_ERR_NONE;
        w_wdone     = 1'b0;
`ifdef PIPELINED_WRITE_RX_TIMEOUT_EN
        w_bubble    = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_cmd.vld) begin
                    if (w_cmd.write_type > WRITE_TYPE_SINGLE_WDONE) begin
                        w_err      = 1'b1;
                        w_err_code = WR_RX_ERR_BAD_TYPE;
                    end else begin
                        w_accept    = 1'b1;
                        w_state_nxt = ST_DATA;
                    end
                end
            end
            default: begin
                case (w_dat.cycle_type)
                    CYC_VALID: begin
                        if (r_cnt == r_last) begin
                            w_err       = 1'b1;
                            w_err_code  = WR_RX_ERR_MISSING_DONE;
                            w_state_nxt = ST_IDLE;
                        end else begin
                            w_store = 1'b1;
                            w_wdone = (r_type == WRITE_TYPE_MULTI_WDONE);
                        end
                    end
                    CYC_DONE: begin
                        w_state_nxt = ST_IDLE;
                        if (r_cnt == r_last) begin
                            w_complete = 1'b1;
                            w_wdone    = (r_type != WRITE_TYPE_STD);
                        end else begin
                            w_err      = 1'b1;
                            w_err_code = WR_RX_ERR_EARLY_DONE;
                        end
                    end
                    default: begin
`ifdef PIPELINED_WRITE_RX_TIMEOUT_EN
                        w_bubble = 1'b1;
                        if (r_bub == BUB_W'(TIMEOUT_CYCLES - 1)) begin
                            w_err       = 1'b1;
                            w_err_code  = WR_RX_ERR_TIMEOUT;
                            w_state_nxt = ST_IDLE;
                        end
`endif
                    end
                endcase
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_last  <= '0;
            r_type  <= '0;
            r_asm   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_cnt  <= '0;
                // num_cycles==0 wraps to MAX_WR_CYCLES-1, i.e. a full-width write.
                r_last <= w_cmd.num_cycles - 1'b1;
                r_type <= w_cmd.write_type;
                r_asm  <= '0;
            end else if (w_store) begin
                r_cnt  <= r_cnt + 1'b1;
                r_asm  <= w_payload;
            end
        end
    end

`ifdef PIPELINED_WRITE_RX_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           r_bub <= '0;
        else if (w_bubble) r_bub <= r_bub + 1'b1;
        else               r_bub <= '0;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdone_o    <= 1'b0;
            err_vld_o  <= 1'b0;
            err_code_o <= '0;
        end else begin
            wdone_o    <= w_wdone;
            err_vld_o  <= w_err || w_overrun;
            err_code_o <= w_overrun ? WR_RX_ERR_OVERRUN : w_err_code;
        end
    end

    pipelined_write_rx_obuf u_obuf (
        .clk       (clk),
        .rst       (rst),
        .i_push    (w_complete),
        .i_dat     (w_payload),
        .i_num     ({1'b0, r_cnt} + 3'd1),
        .i_type    (r_type),
        .i_rdy     (out_rdy_i),
        .o_vld     (out_vld_o),
        .o_dat     (out_dat_o),
        .o_num     (out_num_o),
        .o_type    (out_type_o),
        .o_overrun (w_overrun)
    );

endmodule

// File: tb/tb_pipelined_write_rx.sv
// tb/tb_pipelined_write_rx.sv - directed self-checking bench for pipelined_write_rx
module tb_pipelined_write_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  wr_bus_i;
    logic        out_vld_o;
    logic        out_rdy_i;
    logic [31:0] out_dat_o;
    logic [2:0]  out_num_o;
    logic [2:0]  out_type_o;
    logic        wdone_o;
    logic        err_vld_o;
    logic [2:0]  err_code_o;

    int tests  = 0;
    int failed = 0;
    int n_wdone;
    int n_err;
    logic [2:0] last_err;

    pipelined_write_rx dut (
        .clk        (clk),
        .rst        (rst),
        .wr_bus_i   (wr_bus_i),
        .out_vld_o  (out_vld_o),
        .out_rdy_i  (out_rdy_i),
        .out_dat_o  (out_dat_o),
        .out_num_o  (out_num_o),
        .out_type_o (out_type_o),
        .wdone_o    (wdone_o),
        .err_vld_o  (err_vld_o),
        .err_code_o (err_code_o)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] cmd(input logic [2:0] t, input logic [1:0] n);
        return {1'b1, t, n, 4'b0000};
    endfunction

    function automatic logic [9:0] dv(input logic [7:0] d);
        return {2'b01, d};
    endfunction

    function automatic logic [9:0] dd(input logic [7:0] d);
        return {2'b10, d};
    endfunction

    task automatic step(input logic [9:0] b);
        wr_bus_i = b;
        @(posedge clk);
        #1;
        if (wdone_o) n_wdone++;
        if (err_vld_o) begin
            n_err++;
            last_err = err_code_o;
        end
    endtask

    task automatic clr();
        n_wdone  = 0;
        n_err    = 0;
        last_err = 3'd0;
    endtask

    task automatic drain();
        out_rdy_i = 1'b1;
        step(10'd0);
        out_rdy_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; wr_bus_i = 10'd0; out_rdy_i = 1'b0;
        clr();
        @(posedge clk); #1;
        tests++;
        if ({out_vld_o, out_dat_o, out_num_o, out_type_o, wdone_o, err_vld_o, err_code_o} !== 45'd0) begin
            failed++;
            $display("FAIL reset_outputs got vld=%b dat=%h num=%0d type=%0d wdone=%b err=%b code=%0d expected all 0",
                     out_vld_o, out_dat_o, out_num_o, out_type_o, wdone_o, err_vld_o, err_code_o);
        end
        rst = 1'b0;
        step(10'd0);
    endtask

    task automatic test_std();
        clr();
        step(cmd(3'd0, 2'd2)); step(dv(8'hA5)); step(dd(8'h3C));
        tests++;
        if (out_vld_o !== 1'b1) begin failed++; $display("FAIL std_vld got %b expected 1", out_vld_o); end
        tests++;
        if (out_dat_o !== 32'h00003CA5) begin failed++; $display("FAIL std_dat got %h expected 00003ca5", out_dat_o); end
        tests++;
        if (out_num_o !== 3'd2 || out_type_o !== 3'd0) begin
            failed++; $display("FAIL std_num_type got num=%0d type=%0d expected 2/0", out_num_o, out_type_o);
        end
        tests++;
        if (n_wdone !== 0) begin failed++; $display("FAIL std_wdone got %0d expected 0", n_wdone); end
        drain();
        tests++;
        if (out_vld_o !== 1'b0) begin failed++; $display("FAIL std_drain got vld=%b expected 0", out_vld_o); end
    endtask

    task automatic test_multi();
        clr();
        step(cmd(3'd1, 2'd0)); step(dv(8'h11)); step(dv(8'h22));
        step(10'd0); step(10'd0);
        step(dv(8'h33)); step(dd(8'h44));
        tests++;
        if (n_wdone !== 4) begin failed++; $display("FAIL multi_wdone got %0d expected 4", n_wdone); end
        tests++;
        if (out_vld_o !== 1'b1 || out_dat_o !== 32'h44332211) begin
            failed++; $display("FAIL multi_dat got vld=%b dat=%h expected 1/44332211", out_vld_o, out_dat_o);
        end
        tests++;
        if (out_num_o !== 3'd4 || out_type_o !== 3'd1) begin
            failed++; $display("FAIL multi_num_type got num=%0d type=%0d expected 4/1", out_num_o, out_type_o);
        end
        drain();
    endtask

    task automatic test_errors();
        clr();
        step(cmd(3'd2, 2'd3)); step(dv(8'h01)); step(dd(8'h02));
        tests++;
        if (n_err !== 1 || last_err !== 3'd2) begin
            failed++; $display("FAIL early_done got n_err=%0d code=%0d expected 1/2", n_err, last_err);
        end
        tests++;
        if (out_vld_o !== 1'b0 || n_wdone !== 0) begin
            failed++; $display("FAIL early_side got vld=%b wdone=%0d expected 0/0", out_vld_o, n_wdone);
        end
        step(cmd(3'd0, 2'd1)); step(dd(8'h77));
        tests++;
        if (out_vld_o !== 1'b1 || out_dat_o !== 32'h77 || out_num_o !== 3'd1) begin
            failed++; $display("FAIL after_early got vld=%b dat=%h num=%0d expected 1/77/1", out_vld_o, out_dat_o, out_num_o);
        end
        drain();
        clr();
        step(cmd(3'd0, 2'd1)); step(dv(8'h55));
        tests++;
        if (n_err !== 1 || last_err !== 3'd3 || out_vld_o !== 1'b0) begin
            failed++; $display("FAIL missing_done got n_err=%0d code=%0d vld=%b expected 1/3/0", n_err, last_err, out_vld_o);
        end
        clr();
        step(cmd(3'd5, 2'd1));
        tests++;
        if (n_err !== 1 || last_err !== 3'd1) begin
            failed++; $display("FAIL bad_type got n_err=%0d code=%0d expected 1/1", n_err, last_err);
        end
        step(cmd(3'd0, 2'd1)); step(dd(8'h99));
        tests++;
        if (out_vld_o !== 1'b1 || out_dat_o !== 32'h99 || n_err !== 1) begin
            failed++; $display("FAIL after_bad_type got vld=%b dat=%h n_err=%0d expected 1/99/1", out_vld_o, out_dat_o, n_err);
        end
        drain();
    endtask

    task automatic test_overrun();
        clr();
        out_rdy_i = 1'b0;
        step(cmd(3'd0, 2'd1)); step(dd(8'hAA));
        step(cmd(3'd2, 2'd1)); step(dd(8'hBB));
        tests++;
        if (n_err !== 1 || last_err !== 3'd4) begin
            failed++; $display("FAIL overrun_err got n_err=%0d code=%0d expected 1/4", n_err, last_err);
        end
        tests++;
        if (n_wdone !== 1) begin failed++; $display("FAIL overrun_single_wdone got %0d expected 1", n_wdone); end
        tests++;
        if (out_vld_o !== 1'b1 || out_dat_o !== 32'hAA) begin
            failed++; $display("FAIL overrun_hold got vld=%b dat=%h expected 1/aa", out_vld_o, out_dat_o);
        end
        drain();
        tests++;
        if (out_vld_o !== 1'b0) begin failed++; $display("FAIL overrun_only_first got vld=%b expected 0", out_vld_o); end
    endtask

    task automatic test_back_to_back();
        clr();
        out_rdy_i = 1'b0;
        step(cmd(3'd1, 2'd1)); step(dd(8'h01));
        step(cmd(3'd0, 2'd1));
        out_rdy_i = 1'b1;
        step(dd(8'h02));
        out_rdy_i = 1'b0;
        tests++;
        if (out_vld_o !== 1'b1 || out_dat_o !== 32'h02 || n_err !== 0) begin
            failed++; $display("FAIL b2b_accept_load got vld=%b dat=%h n_err=%0d expected 1/02/0", out_vld_o, out_dat_o, n_err);
        end
        drain();
        step(cmd(3'd0, 2'd1)); step(dd(8'hC3));
        tests++;
        if (out_vld_o !== 1'b1 || out_dat_o !== 32'hC3) begin
            failed++; $display("FAIL b2b_next got vld=%b dat=%h expected 1/c3", out_vld_o, out_dat_o);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        clr();
        step(cmd(3'd1, 2'd2)); step(dv(8'h10));
        rst = 1'b1;
        #1;
        tests++;
        if ({out_vld_o, out_dat_o, out_num_o, out_type_o, wdone_o, err_vld_o, err_code_o} !== 45'd0) begin
            failed++; $display("FAIL reset_mid got vld=%b wdone=%b err=%b expected all 0", out_vld_o, wdone_o, err_vld_o);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        clr();
        step(dd(8'h20)); step(10'd0);
        tests++;
        if (out_vld_o !== 1'b0 || n_err !== 0) begin
            failed++; $display("FAIL reset_mid_after got vld=%b n_err=%0d expected 0/0", out_vld_o, n_err);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

`ifdef PIPELINED_WRITE_RX_TIMEOUT_EN
    task automatic test_timeout();
        clr();
        step(cmd(3'd0, 2'd1));
        for (int i = 0; i < 15; i++) step(10'd0);
        tests++;
        if (n_err !== 0) begin failed++; $display("FAIL timeout_early got n_err=%0d expected 0", n_err); end
        step(10'd0);
        tests++;
        if (n_err !== 1 || last_err !== 3'd5) begin
            failed++; $display("FAIL timeout_err got n_err=%0d code=%0d expected 1/5", n_err, last_err);
        end
        clr();
        step(cmd(3'd0, 2'd1));
        for (int i = 0; i < 15; i++) step(10'd0);
        step(dd(8'h5A));
        tests++;
        if (out_vld_o !== 1'b1 || out_dat_o !== 32'h5A || n_err !== 0) begin
            failed++; $display("FAIL timeout_15 got vld=%b dat=%h n_err=%0d expected 1/5a/0", out_vld_o, out_dat_o, n_err);
        end
        drain();
    endtask
`endif

    initial begin
        test_reset();
        test_std();
        test_multi();
        test_errors();
        test_overrun();
        test_back_to_back();
        test_reset_mid();
`ifdef PIPELINED_WRITE_RX_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
